// File: rtl/alu_mul_seq_if.sv
// Request/response bundle for the iterative multiplier: start + operands in,
// busy/done/product out.
interface alu_mul_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      i_start;
    logic [DATA_WIDTH-1:0]     i_multiplicand;
    logic [DATA_WIDTH-1:0]     i_multiplier;
    logic                      o_busy;
    logic                      o_done;
    logic [2*DATA_WIDTH-1:0]   o_product;

    // Requester side (execute stage / bench)
    modport master (
        output i_start, i_multiplicand, i_multiplier,
        input  o_busy, o_done, o_product
    );

    // Multiplier side
    modport slave (
        input  i_start, i_multiplicand, i_multiplier,
        output o_busy, o_done, o_product
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier. Reuses the shared combinational
// alu (ADD) once per cycle; the dropped carry is recovered by comparison.

// Shared combinational ALU; only ADD is used by the multiplier.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_elemA,
    input  logic [WIDTH-1:0] i_elemB,
    output logic [WIDTH-1:0] o_result
);
    // Select result by opcode; carry/borrow is intentionally not exported
    always_comb begin
        o_result = '0;
        case (i_op)
            2'd0:    o_result = i_elemA + i_elemB;
            2'd1:    o_result = i_elemA - i_elemB;
            2'd2:    o_result = i_elemA & i_elemB;
            default: o_result = i_elemA | i_elemB;
        endcase
    end
endmodule

module alu_mul_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    alu_mul_seq_if.slave  bus
);
    localparam int             CW      = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  LAST    = CW'(DATA_WIDTH - 1);
    localparam logic [1:0]     ALU_ADD = 2'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   accHi;
    logic [DATA_WIDTH-1:0]   lo;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [CW-1:0]           stepCnt;
    logic [DATA_WIDTH-1:0]   addend;
    logic [DATA_WIDTH-1:0]   sum;
    logic                    carry;
    logic [DATA_WIDTH-1:0]   nextAcc;
    logic [DATA_WIDTH-1:0]   nextLo;

    // Add the multiplicand only when the current multiplier bit is set
    assign addend = lo[0] ? mcand : '0;

    alu #(.WIDTH(DATA_WIDTH)) uAlu (
        .i_op    (ALU_ADD),
        .i_elemA (accHi),
        .i_elemB (addend),
        .o_result(sum)
    );

    // Unsigned wrap means the add overflowed; with a zero addend sum==accHi
    assign carry   = (sum < accHi);
    assign nextAcc = {carry, sum[DATA_WIDTH-1:1]};
    assign nextLo  = {sum[0], lo[DATA_WIDTH-1:1]};

    // Control FSM and datapath; busy/done/product are registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            accHi         <= '0;
            lo            <= '0;
            mcand         <= '0;
            stepCnt       <= '0;
            bus.o_busy    <= 1'b0;
            bus.o_done    <= 1'b0;
            bus.o_product <= '0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // DONE also accepts a start so back-to-back issue costs one cycle
                    if (bus.i_start) begin
                        accHi      <= '0;
                        lo         <= bus.i_multiplier;
                        mcand      <= bus.i_multiplicand;
                        stepCnt    <= '0;
                        bus.o_busy <= 1'b1;
                        state      <= BUSY;
                    end else begin
                        state      <= IDLE;
                    end
                end
                BUSY: begin
                    accHi   <= nextAcc;
                    lo      <= nextLo;
                    stepCnt <= stepCnt + 1'b1;
                    if (stepCnt == LAST) begin
                        bus.o_product <= {nextAcc, nextLo};
                        bus.o_busy    <= 1'b0;
                        bus.o_done    <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
